// File: rtl/seven_segment_scanner.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display with
// frame-synchronous double buffering. Define SCAN_BRIGHTNESS_EN to add PWM dimming.
module seven_segment_scanner #(
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] seg1_in,
  input  logic [6:0] seg2_in,
  input  logic [6:0] seg3_in,
  input  logic [6:0] seg4_in,
  input  logic       load,
`ifdef SCAN_BRIGHTNESS_EN
  input  logic [2:0] brightness,
`endif
  output logic [6:0] seg_out,
  output logic [3:0] an_out,
  output logic       frame_done
);

  localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [6:0]    act_q  [4];
  logic [6:0]    act_d  [4];
  logic [6:0]    pend_q [4];
  logic [6:0]    pend_d [4];
  logic          pend_vld_q, pend_vld_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          fd_q, fd_d;
  logic [6:0]    seg_in_s [4];
  logic          slot_end_s, boundary_s, drive_s, lit_s;

  assign seg_in_s[0] = seg1_in;
  assign seg_in_s[1] = seg2_in;
  assign seg_in_s[2] = seg3_in;
  assign seg_in_s[3] = seg4_in;

  // Slot/digit counters and the pending->active double buffer, swapped only at frame start.
  always_comb begin
    slot_end_s = (cnt_q == CNT_LAST);
    boundary_s = slot_end_s && (idx_q == 2'd3);
    cnt_d      = slot_end_s ? {CW{1'b0}} : cnt_q + CW'(1);
    idx_d      = slot_end_s ? idx_q + 2'd1 : idx_q;
    act_d      = act_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (load) begin
      pend_d = seg_in_s;
    end else begin
      pend_d = pend_q;
    end
    if (boundary_s) begin
      pend_vld_d = 1'b0;
      if (load) begin
        act_d = seg_in_s;
      end else if (pend_vld_q) begin
        act_d = pend_q;
      end else begin
        act_d = act_q;
      end
    end else if (load) begin
      pend_vld_d = 1'b1;
    end else begin
      pend_vld_d = pend_vld_q;
    end
  end

`ifdef SCAN_BRIGHTNESS_EN
  localparam int DRIVE_W = DWELL_CYCLES - BLANK_CYCLES;

  logic [2:0]  bri_q, bri_d;
  logic [23:0] on_cnt_s;

  // Lit portion of the drive window; brightness only changes at frame start.
  always_comb begin
    bri_d    = boundary_s ? brightness : bri_q;
    on_cnt_s = ((24'(bri_d) + 24'd1) * 24'(DRIVE_W)) >> 3;
    if (on_cnt_s == 24'd0) begin
      on_cnt_s = 24'd1;
    end else begin
      on_cnt_s = on_cnt_s;
    end
    lit_s = ((24'(cnt_d) - 24'(BLANK_CYCLES)) < on_cnt_s);
  end

  // Brightness register, forced to full on reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      bri_q <= 3'd7;
    end else begin
      bri_q <= bri_d;
    end
  end
`else
  assign lit_s = 1'b1;
`endif

  // Output decode from the next-state values so the registered outputs line up with cnt/idx.
  always_comb begin
    drive_s = (cnt_d >= CNT_BLANK);
    fd_d    = boundary_s;
    if (drive_s && lit_s) begin
      seg_d = act_d[idx_d];
      an_d  = ~(4'b0001 << idx_d);
    end else begin
      seg_d = 7'h7F;
      an_d  = 4'hF;
    end
  end

  // State and output registers with synchronous reset taking priority over load.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q      <= {CW{1'b0}};
      idx_q      <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        act_q[i]  <= 7'h7F;
        pend_q[i] <= 7'h7F;
      end
      pend_vld_q <= 1'b0;
      seg_q      <= 7'h7F;
      an_q       <= 4'hF;
      fd_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      act_q      <= act_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      fd_q       <= fd_d;
    end
  end

  assign seg_out    = seg_q;
  assign an_out     = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Self-checking bench for seven_segment_scanner (DWELL_CYCLES=8, BLANK_CYCLES=2):
// a per-cycle frame-level reference model plus table-driven directed scenarios.
module tb_seven_segment_scanner;

  localparam int D  = 8;
  localparam int B  = 2;
  localparam int FR = 4 * D;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       load  = 1'b0;
  logic [6:0] s_in [4];
  logic [2:0] brightness = 3'd7;
  logic [6:0] seg_out;
  logic [3:0] an_out;
  logic       frame_done;

  seven_segment_scanner #(.DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut (
    .clock      (clock),
    .reset      (reset),
    .seg1_in    (s_in[0]),
    .seg2_in    (s_in[1]),
    .seg3_in    (s_in[2]),
    .seg4_in    (s_in[3]),
    .load       (load),
`ifdef SCAN_BRIGHTNESS_EN
    .brightness (brightness),
`endif
    .seg_out    (seg_out),
    .an_out     (an_out),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  // Reference model: cycles since reset, shown frame contents, latest load.
  int         n = 0;
  logic [6:0] m_disp [4];
  logic [6:0] m_latest [4];
  bit         m_pend  = 1'b0;
  int         m_bri   = 7;
  bit         m_valid = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [3:0] obs_an  [128];
  logic [6:0] obs_seg [128];
  logic       obs_fd  [128];

  typedef struct {
    int         scen;
    int         cyc;
    logic [3:0] an;
    logic [6:0] seg;
    logic       fd;
  } row_t;

  row_t tab [$];

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    int c, i, on;
    logic [3:0] ean;
    logic [6:0] eseg;
    logic       efd;
    @(negedge clock);
    if (m_valid) begin
      c = n % D;
      i = (n / D) % 4;
`ifdef SCAN_BRIGHTNESS_EN
      on = ((m_bri + 1) * (D - B)) / 8;
      if (on < 1) on = 1;
`else
      on = D - B;
`endif
      if (c >= B && (c - B) < on) begin
        ean  = ~(4'b0001 << i);
        eseg = m_disp[i];
      end else begin
        ean  = 4'hF;
        eseg = 7'h7F;
      end
      efd = (n > 0) && (n % FR == 0);
      chk("model_an", n, 32'(an_out), 32'(ean));
      chk("model_seg", n, 32'(seg_out), 32'(eseg));
      chk("model_fd", n, 32'(frame_done), 32'(efd));
      if (n < 128) begin
        obs_an[n]  = an_out;
        obs_seg[n] = seg_out;
        obs_fd[n]  = frame_done;
      end
    end
    @(posedge clock);
    if (reset) begin
      n = 0;
      for (int k = 0; k < 4; k++) begin
        m_disp[k]   = 7'h7F;
        m_latest[k] = 7'h7F;
      end
      m_pend  = 1'b0;
      m_bri   = 7;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (load) begin
        for (int k = 0; k < 4; k++) m_latest[k] = s_in[k];
        m_pend = 1'b1;
      end
      n++;
      if (n % FR == 0) begin
        if (m_pend) begin
          for (int k = 0; k < 4; k++) m_disp[k] = m_latest[k];
        end
        m_pend = 1'b0;
        m_bri  = int'(brightness);
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    load  = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic idle_to(input int target);
    while (n < target) tick();
  endtask

  task automatic load_at(input int cyc, input logic [6:0] a, input logic [6:0] b2,
                         input logic [6:0] c, input logic [6:0] d);
    idle_to(cyc);
    s_in[0] = a; s_in[1] = b2; s_in[2] = c; s_in[3] = d;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic check_rows(input int scen);
    foreach (tab[r]) begin
      if (tab[r].scen == scen) begin
        chk("tab_an", tab[r].cyc, 32'(obs_an[tab[r].cyc]), 32'(tab[r].an));
        chk("tab_seg", tab[r].cyc, 32'(obs_seg[tab[r].cyc]), 32'(tab[r].seg));
        chk("tab_fd", tab[r].cyc, 32'(obs_fd[tab[r].cyc]), 32'(tab[r].fd));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt_hits;
    for (int k = 0; k < 4; k++) s_in[k] = 7'h7F;

    // Reset/release timing and first load (40,79,24,3F at cycle 10)
    tab.push_back('{1, 0, 4'hF, 7'h7F, 1'b0});
    tab.push_back('{1, 1, 4'hF, 7'h7F, 1'b0});
    tab.push_back('{1, 2, 4'hE, 7'h7F, 1'b0});
    tab.push_back('{1, 7, 4'hE, 7'h7F, 1'b0});
    tab.push_back('{1, 11, 4'hD, 7'h7F, 1'b0});
    tab.push_back('{1, 31, 4'h7, 7'h7F, 1'b0});
    tab.push_back('{1, 32, 4'hF, 7'h7F, 1'b1});
    tab.push_back('{1, 33, 4'hF, 7'h7F, 1'b0});
    tab.push_back('{1, 34, 4'hE, 7'h40, 1'b0});
    tab.push_back('{1, 42, 4'hD, 7'h79, 1'b0});
    tab.push_back('{1, 50, 4'hB, 7'h24, 1'b0});
    tab.push_back('{1, 58, 4'h7, 7'h3F, 1'b0});
    tab.push_back('{1, 63, 4'h7, 7'h3F, 1'b0});
    tab.push_back('{1, 64, 4'hF, 7'h7F, 1'b1});
    // Last load in a frame wins
    tab.push_back('{2, 34, 4'hE, 7'h79, 1'b0});
    tab.push_back('{2, 39, 4'hE, 7'h79, 1'b0});
    tab.push_back('{2, 42, 4'hD, 7'h7F, 1'b0});
    // Load on the boundary edge goes straight to the display
    tab.push_back('{3, 30, 4'h7, 7'h7F, 1'b0});
    tab.push_back('{3, 32, 4'hF, 7'h7F, 1'b1});
    tab.push_back('{3, 34, 4'hE, 7'h12, 1'b0});
    tab.push_back('{3, 42, 4'hD, 7'h34, 1'b0});
    tab.push_back('{3, 50, 4'hB, 7'h56, 1'b0});
    tab.push_back('{3, 58, 4'h7, 7'h08, 1'b0});
    tab.push_back('{3, 66, 4'hE, 7'h12, 1'b0});
    // Mid-slot reset discards pending data and ignores a concurrent load
    tab.push_back('{4, 0, 4'hF, 7'h7F, 1'b0});
    tab.push_back('{4, 1, 4'hF, 7'h7F, 1'b0});
    tab.push_back('{4, 2, 4'hE, 7'h7F, 1'b0});
    tab.push_back('{4, 32, 4'hF, 7'h7F, 1'b1});
    tab.push_back('{4, 34, 4'hE, 7'h7F, 1'b0});
    tab.push_back('{4, 42, 4'hD, 7'h7F, 1'b0});
    tab.push_back('{4, 58, 4'h7, 7'h7F, 1'b0});
    // Brightness 3: 2 blank, 3 lit, 3 blank; change at cycle 40 waits for frame at 64
    tab.push_back('{5, 34, 4'hE, 7'h40, 1'b0});
    tab.push_back('{5, 36, 4'hE, 7'h40, 1'b0});
    tab.push_back('{5, 37, 4'hF, 7'h7F, 1'b0});
    tab.push_back('{5, 39, 4'hF, 7'h7F, 1'b0});
    tab.push_back('{5, 44, 4'hD, 7'h79, 1'b0});
    tab.push_back('{5, 45, 4'hF, 7'h7F, 1'b0});
    tab.push_back('{5, 69, 4'hE, 7'h40, 1'b0});
    tab.push_back('{5, 71, 4'hE, 7'h40, 1'b0});

    do_reset();
    load_at(10, 7'h40, 7'h79, 7'h24, 7'h3F);
    idle_to(72);
    check_rows(1);
    cnt_hits = 0;
    for (int k = 1; k < 32; k++) if (obs_fd[k] !== 1'b0) cnt_hits++;
    chk("no_early_frame_done", 31, 32'(cnt_hits), 32'd0);

    do_reset();
    load_at(5, 7'h40, 7'h7F, 7'h7F, 7'h7F);
    load_at(20, 7'h79, 7'h7F, 7'h7F, 7'h7F);
    idle_to(72);
    check_rows(2);
    cnt_hits = 0;
    for (int k = 0; k < 72; k++) if (obs_seg[k] === 7'h40) cnt_hits++;
    chk("overwritten_never_shown", 71, 32'(cnt_hits), 32'd0);

    do_reset();
    load_at(31, 7'h12, 7'h34, 7'h56, 7'h08);
    idle_to(72);
    check_rows(3);

    do_reset();
    load_at(5, 7'h40, 7'h79, 7'h24, 7'h3F);
    idle_to(19);
    s_in[0] = 7'h11; s_in[1] = 7'h22; s_in[2] = 7'h33; s_in[3] = 7'h44;
    reset = 1'b1;
    load  = 1'b1;
    tick();
    reset = 1'b0;
    load  = 1'b0;
    idle_to(72);
    check_rows(4);

`ifdef SCAN_BRIGHTNESS_EN
    brightness = 3'd3;
    do_reset();
    load_at(1, 7'h40, 7'h79, 7'h24, 7'h3F);
    idle_to(40);
    brightness = 3'd7;
    idle_to(72);
    check_rows(5);
`endif

    // Randomized traffic against the model, with extra loads on boundary edges
    do_reset();
    for (int t = 0; t < 800; t++) begin
      if (n % FR == FR - 1) load = ($urandom_range(0, 1) == 0) ? 1'b1 : 1'b0;
      else                  load = ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0;
      reset = ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0;
      for (int k = 0; k < 4; k++) s_in[k] = 7'($urandom_range(0, 127));
      brightness = 3'($urandom_range(0, 7));
      tick();
    end
    reset = 1'b0;
    load  = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seven_segment_scanner.md
SEVEN_SEGMENT_SCANNER -- requirements
Module: seven_segment_scanner

Interface
REQ-001 The block SHALL have parameter DWELL_CYCLES, default 50000, clock cycles per digit slot (legal range 4..2^20).
REQ-002 The block SHALL have parameter BLANK_CYCLES, default 2, dead-time cycles at the start of each slot (legal range 0..DWELL_CYCLES-2).
REQ-003 The block SHALL have port clock, input, 1, the single system clock (rising edge).
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have ports seg1_in, seg2_in, seg3_in and seg4_in, input, 7 each, active-low segment patterns for ones, tens, hundreds and sign, with bit 0=a through bit 6=g.
REQ-006 The block SHALL have port load, input, 1, a strobe that captures seg1_in..seg4_in on the same edge.
REQ-007 The block SHALL have port seg_out, output, 7, the shared active-low segment bus.
REQ-008 The block SHALL have port an_out, output, 4, active-low digit enables, with an_out[0]=seg1 and an_out[3]=seg4.
REQ-009 The block SHALL have port frame_done, output, 1, a one-cycle pulse at each frame start.
REQ-010 The block SHALL have port brightness, input, 3, duty select, present only when SCAN_BRIGHTNESS_EN is defined.

Function
REQ-011 The block SHALL hold slot counter cnt (0..DWELL_CYCLES-1) and digit index idx (0..3), and SHALL increment cnt every cycle.
REQ-012 When cnt=DWELL_CYCLES-1, cnt SHALL wrap to 0 and idx SHALL advance, with 3 wrapping to 0.
REQ-013 A frame SHALL be 4*DWELL_CYCLES cycles, and the frame boundary SHALL be the edge where idx wraps 3->0.
REQ-014 The state SHALL be BLANK when cnt<BLANK_CYCLES; in BLANK, an_out=4'b1111 and seg_out=7'b1111111.
REQ-015 The state SHALL be DRIVE otherwise; in DRIVE, an_out SHALL have only bit idx low and seg_out SHALL equal the active pattern for idx.
REQ-016 seg_out, an_out and frame_done SHALL be registered outputs, aligned with cnt/idx (no extra cycle of lag), and SHALL be glitch-free.
REQ-017 Exactly one an_out bit SHALL be low in DRIVE, and no an_out bit SHALL ever be low in BLANK.
REQ-018 When load=1, the inputs SHALL be captured into pending registers and the pending flag SHALL be set.
REQ-019 At a frame boundary with the pending flag set, pending SHALL be copied to active and the flag cleared.
REQ-020 Load on the boundary edge SHALL bypass pending, so the new inputs become active for the frame starting there and the flag is cleared.
REQ-021 Multiple loads within one frame SHALL result in the last load winning, and intermediate values SHALL never be displayed.
REQ-022 Active patterns SHALL change only at frame boundaries, so no digit tears mid-frame.
REQ-023 frame_done SHALL be 1 for exactly the cycle with cnt=0 and idx=0, except the first such cycle after reset.

Reset
REQ-024 When reset=1 at an edge, the block SHALL set cnt=0, idx=0, all active and pending patterns to 7'b1111111, pending flag=0, seg_out=7'b1111111, an_out=4'b1111 and frame_done=0.
REQ-025 Reset asserted mid-slot SHALL take effect on that edge, abandoning the slot without completing it and discarding pending data.
REQ-026 load SHALL be ignored while reset=1.
REQ-027 After reset deasserts, the first cycle SHALL be cnt=0, idx=0, in BLANK if BLANK_CYCLES>0.

Configuration
REQ-028 With SCAN_BRIGHTNESS_EN defined, the DRIVE window W=DWELL_CYCLES-BLANK_CYCLES SHALL be gated so the digit is on for the first ((brightness+1)*W)/8 DRIVE cycles (integer floor, minimum 1) and blanked as in BLANK for the remainder.
REQ-029 With SCAN_BRIGHTNESS_EN defined, brightness SHALL be sampled only at frame boundaries and on reset (reset samples 3'd7).
REQ-030 Without SCAN_BRIGHTNESS_EN, the brightness port and its logic SHALL be absent, and DRIVE SHALL last the full W cycles.

Verification (DWELL_CYCLES=8, BLANK_CYCLES=2)
REQ-031 The bench SHALL check: reset, then release -> cycles 0-1 have an_out=1111 and seg_out=7F, cycles 2-7 have an_out=1110 and seg_out=7F, no frame_done until cycle 32.
REQ-032 The bench SHALL check: load seg1..4=40,79,24,3F at cycle 10 -> all outputs are 7F through cycle 31, and from cycle 32 slot 0 shows 40, slot 1 shows 79, slot 2 shows 24 and slot 3 shows 3F, with frame_done=1 at cycle 32 only.
REQ-033 The bench SHALL check: load at cycle 5 (seg1=40) then at cycle 20 (seg1=79) -> frame from cycle 32 shows 79 in slot 0, and 40 never appears.
REQ-034 The bench SHALL check: load coinciding with the boundary edge -> new patterns are shown in that frame's slot 0.
REQ-035 The bench SHALL check: reset pulsed at cycle 19 (idx=2) -> next cycle has an_out=1111, seg_out=7F, cnt=0 and idx=0, and prior loads are lost.
REQ-036 The bench SHALL check, with SCAN_BRIGHTNESS_EN and brightness=3 -> each slot has 2 blank cycles, 3 cycles with its an_out bit low, then 3 blank cycles, and a mid-frame brightness change takes effect only at the next frame.
